// File: rtl/floating_multiplication_if.sv
// floating_multiplication_if: operand/result bundle for the binary32 multiplier
interface floating_multiplication_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] result;
  modport master (output A, B, input result);
  modport slave (input A, B, output result);
endinterface

// File: rtl/floating_multiplication.sv
// floating_multiplication: single-cycle binary32 multiply, round-to-nearest-even, flush-to-zero
module floating_multiplication #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  floating_multiplication_if.slave bus
);
  localparam logic [XLEN-1:0] QNAN = XLEN'(32'h7FC00000);
  logic [XLEN-1:0] result_d, result_q, normal;
  logic [7:0] ea, eb;
  logic [22:0] fa, fb, mant;
  logic sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, norm, g, r, st;
  logic [47:0] prod;
  logic [23:0] rnd;
  logic [9:0] exp_f;
  always_comb begin
    ea = bus.A[30:23];
    eb = bus.B[30:23];
    fa = bus.A[22:0];
    fb = bus.B[22:0];
    sign = bus.A[31] ^ bus.B[31];
    a_nan = (ea == 8'hFF) && (fa != '0);
    b_nan = (eb == 8'hFF) && (fb != '0);
    a_inf = (ea == 8'hFF) && (fa == '0);
    b_inf = (eb == 8'hFF) && (fb == '0);
    a_zero = ea == 8'h00;
    b_zero = eb == 8'h00;
    prod = {24'b0, 1'b1, fa} * {24'b0, 1'b1, fb};
    norm = prod[47];
    mant = norm ? prod[46:24] : prod[45:23];
    g = norm ? prod[23] : prod[22];
    r = norm ? prod[22] : prod[21];
    st = norm ? |prod[21:0] : |prod[20:0];
    rnd = {1'b0, mant} + {23'b0, g & (r | st | mant[0])};
    // 10-bit two's complement keeps underflow below zero distinguishable from overflow
    exp_f = {2'b0, ea} + {2'b0, eb} - 10'd127 + {9'b0, norm} + {9'b0, rnd[23]};
    normal = $signed(exp_f) >= 255 ? XLEN'({sign, 8'hFF, 23'b0}) :
             $signed(exp_f) <= 0 ? XLEN'({sign, 31'b0}) :
             XLEN'({sign, exp_f[7:0], rnd[22:0]});
    result_d = (a_nan || b_nan) ? QNAN :
               ((a_zero && b_inf) || (a_inf && b_zero)) ? QNAN :
               (a_inf || b_inf) ? XLEN'({sign, 8'hFF, 23'b0}) :
               (a_zero || b_zero) ? XLEN'({sign, 31'b0}) : normal;
  end
  always_ff @(posedge clk) result_q <= rst ? '0 : result_d;
  assign bus.result = result_q;
endmodule

// File: tb/tb_floating_multiplication.sv
// tb_floating_multiplication: directed binary32 multiply vectors with 1-cycle latency checks
module tb_floating_multiplication;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int fails = 0;
  floating_multiplication_if #(.XLEN(32)) bus ();
  floating_multiplication #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] expv);
    total++;
    assert (bus.result === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, bus.result, expv);
    end
  endtask
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    check(tag, expv);
  endtask
  initial begin
    bus.A = 32'h40000000;
    bus.B = 32'h40400000;
    @(posedge clk);
    #1;
    check("reset_hold0", 32'h00000000);
    @(posedge clk);
    #1;
    check("reset_hold1", 32'h00000000);
    rst = 1'b0;
    step("first_edge_2x3", 32'h40000000, 32'h40400000, 32'h40C00000);
    step("neg_half_x_neg_6p4", 32'hBF000000, 32'hC0CCCCCC, 32'h404CCCCC);
    step("3p2_x_4p2", 32'h404CCCCC, 32'h40866666, 32'h41570A3C);
    step("round_up_lsb", 32'h3F800001, 32'h3F800001, 32'h3F800002);
    step("tie_odd_even", 32'h3F800001, 32'h3FC00000, 32'h3FC00002);
    step("round_carry_out", 32'h3FFFFFFF, 32'h3F800001, 32'h40000000);
    step("norm_shift", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    step("overflow_inf", 32'h7F000000, 32'h40000000, 32'h7F800000);
    step("neg_overflow", 32'hFF000000, 32'h40000000, 32'hFF800000);
    step("zero_x_inf", 32'h00000000, 32'h7F800000, 32'h7FC00000);
    step("inf_x_negzero", 32'hFF800000, 32'h80000000, 32'h7FC00000);
    step("negzero_x_3", 32'h80000000, 32'h40400000, 32'h80000000);
    step("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
    step("min_normal_keep", 32'h00800000, 32'h3F800000, 32'h00800000);
    step("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    step("nan_x_zero", 32'h00000000, 32'hFF800001, 32'h7FC00000);
    step("inf_x_neg2", 32'h7F800000, 32'hC0000000, 32'hFF800000);
    step("neginf_x_inf", 32'hFF800000, 32'h7F800000, 32'hFF800000);
    step("subnormal_zero", 32'h00000001, 32'hC0000000, 32'h80000000);
    bus.A = 32'h40000000;
    bus.B = 32'h40400000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", 32'h00000000);
    rst = 1'b0;
    step("resume_after_reset", 32'hBF000000, 32'hC0CCCCCC, 32'h404CCCCC);
    step("resume_next", 32'h40000000, 32'h40400000, 32'h40C00000);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
